// File: rtl/amber48_uart_tx.sv
// ---------------------------------------------------------------------------
// amber48_uart_tx -- 8N1 UART transmitter fed from the dmem UART MMIO path.
//
// Optional feature macro: AMBER48_UART_TX_FIFO_EN
//   defined   : bytes queue in a FIFO_DEPTH-entry circular buffer
//   undefined : single holding register, ready only while idle
//
// Parameters
//   CLKS_PER_BIT : clk_i cycles per serial bit (>= 2)
//   FIFO_DEPTH   : queue depth when the FIFO is built (power of two, >= 2)
//
// Ports
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   valid_i   : byte offer
//   data_i    : byte to transmit
//   ready_o   : byte can be accepted this cycle (registered)
//   tx_o      : serial line, idle high
//   busy_o    : frame in progress or byte queued
//   overrun_o : one-cycle pulse when an offered byte is dropped
// ---------------------------------------------------------------------------
module amber48_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       overrun_o
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("amber48_uart_tx: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

    logic          accept;
    logic          bit_end;
    logic          start_now;
    logic          held;
    logic [7:0]    next_byte;

    assign accept  = valid_i & ready_q;
    assign bit_end = (baud_q == '0);

`ifdef AMBER48_UART_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          q_nonempty, push, pop, slot_open, pop_soon;

    assign q_nonempty = (cnt_q != '0);
    // A new frame may begin from IDLE or on the last cycle of a stop bit.
    assign slot_open  = (state_q == IDLE) || (state_q == STOP && bit_end);
    assign start_now  = slot_open && (q_nonempty || accept);
    assign pop        = start_now && q_nonempty;
    // With an empty queue the accepted byte goes straight into the shifter.
    assign push       = accept && !(start_now && !q_nonempty);
    assign next_byte  = q_nonempty ? mem_q[rd_q] : data_i;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Keep ready high on the cycle a full queue pops, so a byte offered then
    // is taken in the freed slot instead of being dropped.
    assign pop_soon = (state_d == STOP) && (baud_d == '0);
    assign ready_d  = (cnt_d != FULL) || pop_soon;
    assign held     = (cnt_d != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end
`else
    assign start_now = (state_q == IDLE) && accept;
    assign next_byte = data_i;
    assign ready_d   = (state_d == IDLE);
    assign held      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (start_now) begin
                    state_d = START;
                    baud_d  = BAUD_LAST;
                    shift_d = next_byte;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = BAUD_LAST;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (start_now) begin
                        state_d = START;
                        baud_d  = BAUD_LAST;
                        shift_d = next_byte;
                    end else begin
                        state_d = IDLE;
                        baud_d  = '0;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so tx_o changes on the
    // same edge the state does.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d    = (state_d != IDLE) || held;
        overrun_d = valid_i && !ready_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign ready_o   = ready_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_amber48_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_amber48_uart_tx -- directed self-checking bench for amber48_uart_tx with
// CLKS_PER_BIT=4. Builds with or without AMBER48_UART_TX_FIFO_EN.
// Sample point s means #1 after clock edge s, where edge 0 is the edge that
// accepts the first byte of a test.
// ---------------------------------------------------------------------------
module tb_amber48_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic       overrun_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    amber48_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles into a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int unsigned k);
        int unsigned bi;
        bi = k / CPB;
        if (bi == 0) return 1'b0;
        if (bi >= 9) return 1'b1;
        return b[bi-1];
    endfunction

    logic [7:0] exp_q [$];

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",      32'(tx_o),      32'd1);
        check("rst_ready",   32'(ready_o),   32'd0);
        check("rst_busy",    32'(busy_o),    32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        rst_ni = 1'b1;
        step();
        check("ready_after_rst", 32'(ready_o), 32'd1);
        step();

        // Single byte 0xA5
        valid_i = 1'b1;
        data_i  = 8'hA5;
        step();
        valid_i = 1'b0;
        for (int unsigned s = 0; s < FRAME; s++) begin
            check("a5_tx", 32'(tx_o), 32'(exp_bit(8'hA5, s)));
            if (s == 20) check("a5_busy_mid", 32'(busy_o), 32'd1);
            if (s == FRAME - 1) check("a5_busy_last", 32'(busy_o), 32'd1);
            step();
        end
        check("a5_busy_end", 32'(busy_o), 32'd0);
        check("a5_tx_end",   32'(tx_o),   32'd1);
        check("a5_ready_end", 32'(ready_o), 32'd1);
        step();

`ifndef AMBER48_UART_TX_FIFO_EN
        // No-FIFO: second byte offered mid-frame is dropped
        valid_i = 1'b1;
        data_i  = 8'h12;
        step();
        valid_i = 1'b0;
        for (int unsigned s = 0; s < FRAME; s++) begin
            check("nf_tx", 32'(tx_o), 32'(exp_bit(8'h12, s)));
            if (s == 2) begin
                check("nf_ready_busy", 32'(ready_o), 32'd0);
                valid_i = 1'b1;
                data_i  = 8'h34;
            end
            if (s == 3) begin
                valid_i = 1'b0;
                check("nf_overrun_pulse", 32'(overrun_o), 32'd1);
            end
            if (s == 4) check("nf_overrun_clear", 32'(overrun_o), 32'd0);
            if (s == FRAME - 1) check("nf_ready_last", 32'(ready_o), 32'd0);
            step();
        end
        check("nf_ready_back", 32'(ready_o), 32'd1);
        check("nf_busy_end",   32'(busy_o),  32'd0);
        step();
        check("nf_no_resend_tx",   32'(tx_o),   32'd1);
        check("nf_no_resend_busy", 32'(busy_o), 32'd0);
        step();
`else
        // Back-to-back 0x55, 0x0F, 0xFF
        exp_q = '{8'h55, 8'h0F, 8'hFF};
        valid_i = 1'b1;
        data_i  = 8'h55;
        check("b2b_ready0", 32'(ready_o), 32'd1);
        step();
        for (int unsigned s = 0; s < 3 * FRAME; s++) begin
            if (s == 0) begin
                check("b2b_ready1", 32'(ready_o), 32'd1);
                data_i = 8'h0F;
            end
            if (s == 1) begin
                check("b2b_ready2", 32'(ready_o), 32'd1);
                data_i = 8'hFF;
            end
            if (s == 2) begin
                valid_i = 1'b0;
                check("b2b_ready3", 32'(ready_o), 32'd1);
            end
            check("b2b_tx", 32'(tx_o), 32'(exp_bit(exp_q[s / FRAME], s % FRAME)));
            check("b2b_busy", 32'(busy_o), 32'd1);
            step();
        end
        check("b2b_busy_end", 32'(busy_o), 32'd0);
        step();

        // Overrun with a full queue, then accept on the pop cycle
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
        valid_i = 1'b1;
        data_i  = 8'h01;
        step();
        for (int unsigned s = 0; s < 6 * FRAME; s++) begin
            if (s < 4) begin
                check("ov_ready_open", 32'(ready_o), 32'd1);
                check("ov_no_pulse",   32'(overrun_o), 32'd0);
                data_i = 8'(s + 2);
            end
            if (s == 4) begin
                check("ov_ready_full", 32'(ready_o), 32'd0);
                data_i = 8'h06;
            end
            if (s == 5) begin
                valid_i = 1'b0;
                check("ov_pulse", 32'(overrun_o), 32'd1);
            end
            if (s == 6)  check("ov_pulse_clear", 32'(overrun_o), 32'd0);
            if (s == 20) check("ov_ready_mid",   32'(ready_o),   32'd0);
            if (s == FRAME - 1) begin
                check("pop_ready_open", 32'(ready_o), 32'd1);
                valid_i = 1'b1;
                data_i  = 8'h77;
            end
            if (s == FRAME) begin
                valid_i = 1'b0;
                check("pop_no_overrun", 32'(overrun_o), 32'd0);
                check("pop_still_full", 32'(ready_o),   32'd0);
            end
            check("ov_tx", 32'(tx_o), 32'(exp_bit(exp_q[s / FRAME], s % FRAME)));
            step();
        end
        check("ov_busy_end", 32'(busy_o), 32'd0);
        check("ov_tx_end",   32'(tx_o),   32'd1);
        step();
`endif

        // Reset mid-frame at data bit 3 of 0xC3
        valid_i = 1'b1;
        data_i  = 8'hC3;
        step();
        valid_i = 1'b0;
        for (int unsigned s = 0; s < 17; s++) begin
            check("c3_tx", 32'(tx_o), 32'(exp_bit(8'hC3, s)));
            step();
        end
        check("c3_bit3_low", 32'(tx_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check("c3_rst_tx",    32'(tx_o),    32'd1);
        check("c3_rst_busy",  32'(busy_o),  32'd0);
        check("c3_rst_ready", 32'(ready_o), 32'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        check("c3_rel_ready", 32'(ready_o), 32'd1);
        check("c3_rel_busy",  32'(busy_o),  32'd0);
        check("c3_rel_tx",    32'(tx_o),    32'd1);
        repeat (8) begin
            step();
            check("c3_stays_idle", 32'(tx_o), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amber48_uart_tx.md
AMBER48_UART_TX -- requirements
Module: amber48_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_i cycles per serial bit; legal range is 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte-queue depth when the FIFO is compiled in; must be a power of two, 2 or more.
REQ-003 SHALL have port clk_i, input, 1 bit: clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1 bit: byte offer, driven by the dmem UART MMIO path.
REQ-006 SHALL have port data_i, input, 8 bits: byte to transmit.
REQ-007 SHALL have port ready_o, output, 1 bit: byte can be accepted this cycle.
REQ-008 SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy_o, output, 1 bit: frame in progress or byte queued.
REQ-010 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-011 SHALL accept a byte on a rising clk_i edge where valid_i and ready_o are both high.
REQ-012 SHALL drive ready_o from registered state only, with no combinational path from valid_i or data_i.
REQ-013 SHALL drop the byte and pulse overrun_o high for exactly the next cycle when valid_i is high and ready_o is low; internal state is unchanged.
REQ-014 SHALL frame each byte as 8N1: one start bit (0), data bits LSB first, one stop bit (1).
REQ-015 SHALL implement states IDLE, START, DATA and STOP. Transitions: IDLE goes to START when a byte is pending; START goes to DATA after one bit time; DATA goes to STOP after 8 bit times; STOP goes to START if a byte is pending, otherwise to IDLE.
REQ-016 SHALL hold each bit on tx_o for exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that reloads on every bit boundary.
REQ-017 SHALL drive tx_o low on the edge following acceptance when in IDLE with nothing queued, so acceptance-to-start latency is 1 cycle.
REQ-018 SHALL send back-to-back frames with no idle gap between the stop bit and the next start bit; a frame is exactly 10*CLKS_PER_BIT cycles.
REQ-019 SHALL hold tx_o at 1 in IDLE and STOP.
REQ-020 SHALL assert busy_o when the state is not IDLE or any byte is held; busy_o falls on the cycle IDLE is re-entered with nothing pending.
REQ-021 SHALL, when acceptance and pop of the queue head occur in the same cycle with the queue full, complete both (occupancy unchanged) without asserting overrun_o.

Reset
REQ-022 SHALL, while rst_ni is low, force: state IDLE, tx_o=1, ready_o=0, busy_o=0, overrun_o=0, baud counter 0, bit index 0, queue empty.
REQ-023 SHALL drive ready_o=1 on the first clk_i edge after rst_ni deasserts.
REQ-024 SHALL abort any frame when reset asserts mid-frame; tx_o returns high immediately and queued bytes are discarded.

Configuration
REQ-025 SHALL, with macro AMBER48_UART_TX_FIFO_EN defined, buffer bytes in a FIFO_DEPTH circular queue using wrap-around read/write pointers plus a count. ready_o = count < FIFO_DEPTH. A byte is popped at START entry.
REQ-026 SHALL, without AMBER48_UART_TX_FIFO_EN, use a single holding register. ready_o = 1 only when in IDLE with the register empty; ready_o is 0 for the whole frame; FIFO_DEPTH is ignored.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL cover single byte: reset, then send 0xA5 once -> tx_o reads 0,1,0,1,0,0,1,0,1,1 (start, 8 data bits LSB first, stop), each bit held 4 cycles; busy_o falls at cycle 41.
REQ-028 SHALL cover back-to-back with the FIFO macro defined: send 0x55, 0x0F, 0xFF on consecutive cycles -> ready_o stays 1; three 40-cycle frames follow with no gap.
REQ-029 SHALL cover overrun with the FIFO macro defined and FIFO_DEPTH=4: send 6 consecutive bytes starting in IDLE -> first 5 accepted (1 in flight, 4 queued); 6th dropped with one overrun_o pulse.
REQ-030 SHALL cover no-FIFO build: send 0x12, then 0x34 at cycle 3 -> 0x34 dropped with overrun_o pulse; ready_o returns to 1 at cycle 41.
REQ-031 SHALL cover reset mid-frame: assert rst_ni low at data bit 3 of 0xC3 -> tx_o=1 immediately; after release, ready_o=1 and busy_o=0.
REQ-032 SHALL cover simultaneous accept and pop with the FIFO full: offer a byte on the START-entry cycle -> accepted, no overrun_o pulse, count unchanged.
